// File: rtl/usb_tx_bit_timer_pkg.sv
// Shared types and constants for the USB full-speed transmit bit timer.
// Line states are encoded as {d_plus, d_minus}.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SYNC    = 3'd1,
    DATA    = 3'd2,
    EOP_SE0 = 3'd3,
    EOP_J   = 3'd4
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE    = 8'h80;
  localparam int         EOP_SE0_BITS = 2;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  // NRZI: a 0 toggles between J and K, a 1 holds the current level.
  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
    if (bit_val) return line;
    return (line == LINE_J) ? LINE_K : LINE_J;
  endfunction

endpackage

// File: rtl/usb_tx_bit_timer_if.sv
// Byte handshake and line outputs of the USB TX bit timer.
// Handshake: a byte moves from the packet layer when tx_valid and tx_ready are
// both high in the same cycle; tx_ready is a single-cycle strobe at each byte
// boundary and tx_valid low at that strobe ends the packet.
interface usb_tx_bit_timer_if;
  import usb_tx_pkg::*;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       d_plus;
  logic       d_minus;
  logic       tx_active;
  logic       tx_done;
  tx_state_t  dbg_state;
  logic [3:0] dbg_count;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, d_plus, d_minus, tx_active, tx_done, dbg_state, dbg_count
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, d_plus, d_minus, tx_active, tx_done, dbg_state, dbg_count
  );

endinterface

// File: rtl/usb_tx_bit_timer_flex_counter.sv
// Generic rollover counter: counts 0..rollover_val while enabled, then wraps.
// rollover_flag is high during the cycle in which the terminal count is held.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  assign rollover_flag = count_enable && !clear && (count_out == rollover_val);

  // Count register: synchronous clear wins over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               count_out <= '0;
    else if (clear)        count_out <= '0;
    else if (count_enable) count_out <= rollover_flag ? '0 : count_out + 1'b1;
  end

endmodule

// File: rtl/usb_tx_bit_timer.sv
// USB full-speed transmit bit timer / serializer: SYNC, LSB-first data with
// NRZI encoding, then EOP (SE0, SE0, J). Optional bit stuffing is built when
// the macro USB_TX_BIT_STUFF_EN is defined.
module usb_tx_bit_timer
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  usb_tx_bit_timer_if.slave    bus
);

  tx_state_t  state, next_state;
  logic [3:0] bit_count;
  logic       bit_strobe;
  logic [7:0] shift_q;
  logic [7:0] next_shift;
  logic [2:0] bit_idx;
  logic [1:0] line_q;
  logic       data_phase;
  logic       data_strobe;
  logic       boundary;
  logic       stuff_now;
  logic       end_pending;
  logic       stuff_owed;
  logic       stuff_done;

  flex_counter #(.NUM_CNT_BITS(4)) u_bit_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (state == IDLE),
    .count_enable (1'b1),
    .rollover_val (4'(CLKS_PER_BIT - 1)),
    .count_out    (bit_count),
    .rollover_flag(bit_strobe)
  );

  assign data_phase  = (state == SYNC) || (state == DATA);
  // data_strobe ends a real data bit; stuff_done ends an inserted stuff bit.
  assign data_strobe = bit_strobe && data_phase && !stuff_now;
  assign stuff_done  = bit_strobe && data_phase && stuff_now;
  assign boundary    = data_strobe && (bit_idx == 3'd7);
  assign next_shift  = (boundary && bus.tx_valid) ? bus.tx_data : {1'b0, shift_q[7:1]};

`ifdef USB_TX_BIT_STUFF_EN
  logic [2:0] ones_cnt;

  // Sixth consecutive 1 (five already counted plus the current bit) owes a stuff bit.
  assign stuff_owed = data_strobe && shift_q[0] && (ones_cnt == 3'd5);

  // Ones counter and stuff-bit tracking; end_pending marks a stuff bit after the last byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_cnt    <= '0;
      stuff_now   <= 1'b0;
      end_pending <= 1'b0;
    end else if (state == IDLE) begin
      ones_cnt    <= '0;
      stuff_now   <= 1'b0;
      end_pending <= 1'b0;
    end else if (stuff_done) begin
      stuff_now   <= 1'b0;
      end_pending <= 1'b0;
    end else if (data_strobe) begin
      if (stuff_owed) begin
        ones_cnt    <= '0;
        stuff_now   <= 1'b1;
        end_pending <= boundary && !bus.tx_valid;
      end else begin
        ones_cnt <= shift_q[0] ? ones_cnt + 3'd1 : 3'd0;
      end
    end
  end
`else
  assign stuff_owed  = 1'b0;
  assign stuff_now   = 1'b0;
  assign end_pending = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode, advancing only on bit strobes once a packet is running.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.tx_valid) next_state = SYNC;
      SYNC, DATA: begin
        if (stuff_done && end_pending) next_state = EOP_SE0;
        else if (boundary) begin
          if (bus.tx_valid)     next_state = DATA;
          else if (!stuff_owed) next_state = EOP_SE0;
        end
      end
      EOP_SE0: if (bit_strobe && (bit_idx == 3'(EOP_SE0_BITS - 1))) next_state = EOP_J;
      EOP_J:   if (bit_strobe) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shifter, bit index and registered line level; the line changes only at bit starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bit_idx <= '0;
      line_q  <= LINE_J;
    end else begin
      case (state)
        IDLE: begin
          line_q <= LINE_J;
          if (bus.tx_valid) begin
            shift_q <= SYNC_BYTE;
            bit_idx <= '0;
            line_q  <= nrzi_next(LINE_J, SYNC_BYTE[0]);
          end
        end
        SYNC, DATA: begin
          if (stuff_done) begin
            if (end_pending) begin
              bit_idx <= '0;
              line_q  <= LINE_SE0;
            end else begin
              line_q  <= nrzi_next(line_q, shift_q[0]);
            end
          end else if (data_strobe) begin
            if (boundary && !bus.tx_valid) begin
              bit_idx <= '0;
              line_q  <= stuff_owed ? nrzi_next(line_q, 1'b0) : LINE_SE0;
            end else begin
              shift_q <= next_shift;
              bit_idx <= bit_idx + 3'd1;
              line_q  <= stuff_owed ? nrzi_next(line_q, 1'b0) : nrzi_next(line_q, next_shift[0]);
            end
          end
        end
        EOP_SE0: begin
          if (bit_strobe) begin
            if (bit_idx == 3'(EOP_SE0_BITS - 1)) begin
              bit_idx <= '0;
              line_q  <= LINE_J;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        default: line_q <= LINE_J;
      endcase
    end
  end

  // Handshake and status outputs, decoded from the current state.
  always_comb begin
    bus.tx_ready  = boundary;
    bus.tx_done   = (state == EOP_J) && bit_strobe;
    bus.tx_active = (state != IDLE);
    bus.dbg_state = state;
    bus.dbg_count = bit_count;
  end

  assign bus.d_plus  = line_q[1];
  assign bus.d_minus = line_q[0];

endmodule

// File: tb/tb_usb_tx_bit_timer.sv
// Self-checking bench for usb_tx_bit_timer: two instances (8 and 4 clocks per
// bit) checked cycle by cycle against a bit-stream model of the packet.
module tb_usb_tx_bit_timer;
  import usb_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tv  = 1'b0;
  logic [7:0] td  = 8'h00;
  logic       sel = 1'b0;
  int         cpb = 8;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];
  int         rdy_q[$];
  int         acc_q[$];
  int         last_active;
  int         ready_seen;

  usb_tx_bit_timer_if if8();
  usb_tx_bit_timer_if if4();

  assign if8.tx_valid = sel ? 1'b0 : tv;
  assign if4.tx_valid = sel ? tv : 1'b0;
  assign if8.tx_data  = td;
  assign if4.tx_data  = td;

  usb_tx_bit_timer #(.CLKS_PER_BIT(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  usb_tx_bit_timer #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic [1:0] obs_line;
  logic       obs_ready, obs_active, obs_done;

  always_comb begin
    if (sel) begin
      obs_line   = {if4.d_plus, if4.d_minus};
      obs_ready  = if4.tx_ready;
      obs_active = if4.tx_active;
      obs_done   = if4.tx_done;
    end else begin
      obs_line   = {if8.d_plus, if8.d_minus};
      obs_ready  = if8.tx_ready;
      obs_active = if8.tx_active;
      obs_done   = if8.tx_done;
    end
  end

  // Clock.
  always #5 clk = ~clk;

  // Reference model: raw bit stream (SYNC + bytes LSB first), optional
  // stuffing, NRZI levels, then EOP. rdy_q holds the symbol index of the
  // last real bit of each group (SYNC and every byte).
  task automatic build_model(input logic [7:0] bytes[$]);
    logic syms[$];
    logic [7:0] val;
    logic [1:0] lvl;
    int ones;
    exp_q.delete();
    rdy_q.delete();
    ones = 0;
    for (int g = 0; g <= bytes.size(); g++) begin
      val = (g == 0) ? 8'h80 : bytes[g-1];
      for (int i = 0; i < 8; i++) begin
        syms.push_back(val[i]);
        if (i == 7) rdy_q.push_back(syms.size() - 1);
`ifdef USB_TX_BIT_STUFF_EN
        if (val[i]) begin
          ones++;
          if (ones == 6) begin
            syms.push_back(1'b0);
            ones = 0;
          end
        end else begin
          ones = 0;
        end
`endif
      end
    end
    lvl = 2'b10;
    foreach (syms[i]) begin
      if (!syms[i]) lvl = (lvl == 2'b10) ? 2'b01 : 2'b10;
      exp_q.push_back(lvl);
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  // Drives one packet and checks every active cycle plus the idle cycle after.
  task automatic run_packet(input logic [7:0] bytes[$], input bit noise);
    int n_cyc, nb, k, s;
    bit is_rdy;
    build_model(bytes);
    nb = bytes.size();
    n_cyc = exp_q.size() * cpb;
    acc_q.delete();
    last_active = 0;
    ready_seen = 0;
    k = 0;
    @(posedge clk); #1;
    tv = 1'b1;
    td = (nb > 0) ? bytes[0] : 8'($urandom);
    @(posedge clk); #1;
    for (int c = 0; c < n_cyc; c++) begin
      s = c / cpb;
      is_rdy = (k < rdy_q.size()) && (c == rdy_q[k] * cpb + cpb - 1);
      if (is_rdy || !noise) begin
        tv = (k < nb);
        td = (k < nb) ? bytes[k] : 8'h00;
      end else begin
        tv = 1'($urandom_range(0, 1));
        td = 8'($urandom);
      end
      @(negedge clk);
      checks++;
      if (obs_line !== exp_q[s]) begin
        errors++;
        $display("FAIL line cyc=%0d got=%b exp=%b", c, obs_line, exp_q[s]);
      end
      checks++;
      if (obs_ready !== is_rdy) begin
        errors++;
        $display("FAIL tx_ready cyc=%0d got=%b exp=%b", c, obs_ready, is_rdy);
      end
      checks++;
      if (obs_done !== (c == n_cyc - 1)) begin
        errors++;
        $display("FAIL tx_done cyc=%0d got=%b exp=%b", c, obs_done, (c == n_cyc - 1));
      end
      if (obs_active === 1'b1) last_active++;
      if (obs_ready === 1'b1) ready_seen++;
      if (obs_ready === 1'b1 && tv) acc_q.push_back(c);
      if (is_rdy) k++;
      @(posedge clk); #1;
    end
    tv = 1'b0;
    @(negedge clk);
    if (obs_active === 1'b1) last_active++;
    checks++;
    if (obs_active !== 1'b0 || obs_line !== 2'b10 || obs_done !== 1'b0 || obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after act=%b line=%b done=%b rdy=%b exp act=0 line=10 done=0 rdy=0",
               obs_active, obs_line, obs_done, obs_ready);
    end
    checks++;
    if (last_active !== n_cyc) begin
      errors++;
      $display("FAIL active_len got=%0d exp=%0d", last_active, n_cyc);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    cpb = 8;
    @(negedge clk);
    checks++;
    if (obs_line !== 2'b10 || obs_active !== 1'b0 || obs_ready !== 1'b0 || obs_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold line=%b act=%b rdy=%b done=%b exp 10/0/0/0", obs_line, obs_active, obs_ready, obs_done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (obs_line !== 2'b10 || obs_active !== 1'b0 || obs_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle line=%b act=%b rdy=%b exp 10/0/0", obs_line, obs_active, obs_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tv = 1'b1;
    td = 8'h5A;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (if8.dbg_state !== DATA) begin
      errors++;
      $display("FAIL mid_data_state got=%0d exp=%0d", if8.dbg_state, DATA);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_line !== 2'b10 || obs_active !== 1'b0 || obs_ready !== 1'b0 || obs_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_data line=%b act=%b rdy=%b done=%b exp 10/0/0/0", obs_line, obs_active, obs_ready, obs_done);
    end
    tv = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs_line !== 2'b10 || obs_done !== 1'b0 || obs_active !== 1'b0) begin
        errors++;
        $display("FAIL reset_after cyc=%0d line=%b done=%b act=%b exp 10/0/0", i, obs_line, obs_done, obs_active);
      end
    end
  endtask

  task automatic test_one_byte();
    logic [7:0] q[$];
    sel = 1'b0;
    cpb = 8;
    q = {8'h00};
    run_packet(q, 1'b0);
    checks++;
    if (last_active !== 152) begin
      errors++;
      $display("FAIL one_byte_active got=%0d exp=152", last_active);
    end
    checks++;
    if (acc_q.size() !== 1 || ready_seen !== 2 || acc_q[0] !== 63) begin
      errors++;
      $display("FAIL one_byte_accept n=%0d strobes=%0d first=%0d exp n=1 strobes=2 first=63",
               acc_q.size(), ready_seen, (acc_q.size() > 0) ? acc_q[0] : -1);
    end
  endtask

  task automatic test_zero_byte();
    logic [7:0] q[$];
    sel = 1'b0;
    cpb = 8;
    q.delete();
    run_packet(q, 1'b0);
    checks++;
    if (last_active !== 88 || ready_seen !== 1 || acc_q.size() !== 0) begin
      errors++;
      $display("FAIL zero_byte active=%0d strobes=%0d acc=%0d exp 88/1/0", last_active, ready_seen, acc_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q[$];
    sel = 1'b0;
    cpb = 8;
    q = {8'hA5, 8'h3C};
    run_packet(q, 1'b0);
    checks++;
    if (acc_q.size() !== 2 || acc_q[1] - acc_q[0] !== 64) begin
      errors++;
      $display("FAIL b2b_accepts n=%0d gap=%0d exp n=2 gap=64", acc_q.size(),
               (acc_q.size() == 2) ? acc_q[1] - acc_q[0] : -1);
    end
  endtask

  task automatic test_bit_stuff();
    logic [7:0] q[$];
    int exp_len;
    sel = 1'b0;
    cpb = 8;
    q = {8'hFF};
`ifdef USB_TX_BIT_STUFF_EN
    exp_len = (8 + 9 + 3) * 8;
`else
    exp_len = (8 + 8 + 3) * 8;
`endif
    run_packet(q, 1'b0);
    checks++;
    if (last_active !== exp_len) begin
      errors++;
      $display("FAIL stuff_ff_active got=%0d exp=%0d", last_active, exp_len);
    end
  endtask

  task automatic test_cpb4();
    logic [7:0] q[$];
    sel = 1'b1;
    cpb = 4;
    q = {8'h81};
    run_packet(q, 1'b0);
    checks++;
    if (acc_q.size() !== 1 || acc_q[0] !== 31) begin
      errors++;
      $display("FAIL cpb4_accept n=%0d first=%0d exp n=1 first=31", acc_q.size(),
               (acc_q.size() > 0) ? acc_q[0] : -1);
    end
    sel = 1'b0;
    cpb = 8;
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int nb;
    for (int p = 0; p < 8; p++) begin
      sel = 1'($urandom_range(0, 1));
      cpb = sel ? 4 : 8;
      nb = $urandom_range(0, 3);
      q.delete();
      for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
      run_packet(q, 1'b1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    sel = 1'b0;
    cpb = 8;
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_zero_byte();
    test_back_to_back();
    test_bit_stuff();
    test_cpb4();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
